// File: rtl/fir_mac_serial_pkg.sv
// Shared state encoding and sizing helpers for the time-multiplexed FIR MAC.
package fir_mac_serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } fir_state_e;

  function automatic int addr_width(input int num_taps);
    return (num_taps > 1) ? $clog2(num_taps) : 1;
  endfunction

  // Product width plus log2(taps) guard bits: the sum of NUM_TAPS products cannot overflow.
  function automatic int acc_width(input int data_w, input int coef_w, input int num_taps);
    return data_w + coef_w + addr_width(num_taps);
  endfunction

endpackage

// File: rtl/fir_mac_serial_saturate.sv
// Narrows the accumulator: arithmetic shift by FRAC_BITS (toward -inf), then clamp to DATA_WIDTH.
module fir_mac_serial_saturate #(
  parameter int ACC_W      = 46,
  parameter int DATA_WIDTH = 24,
  parameter int FRAC_BITS  = 17
) (
  input  logic signed [ACC_W-1:0]      iv_acc,
  output logic signed [DATA_WIDTH-1:0] ov_data,
  output logic                         o_sat
);

  localparam logic signed [ACC_W-1:0] MAX_V =
    {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V =
    {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    shifted = iv_acc >>> FRAC_BITS;
    o_sat   = 1'b0;
    ov_data = shifted[DATA_WIDTH-1:0];
    if (shifted > MAX_V) begin
      ov_data = MAX_V[DATA_WIDTH-1:0];
      o_sat   = 1'b1;
    end else if (shifted < MIN_V) begin
      ov_data = MIN_V[DATA_WIDTH-1:0];
      o_sat   = 1'b1;
    end
  end

endmodule

// File: rtl/fir_mac_serial.sv
// Serial FIR: one signed multiplier walks all taps per sample, with a registered product stage.
//  state    | meaning
//  ST_IDLE  | ready for a sample and coefficient writes
//  ST_MAC   | one tap product per cycle, tap 0..NUM_TAPS-1
//  ST_DRAIN | fold last product, narrow and load the output
//  ST_OUT   | hold result until downstream takes it
module fir_mac_serial
  import fir_mac_serial_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int COEF_WIDTH = 18,
  parameter int NUM_TAPS   = 16,
  parameter int FRAC_BITS  = 17,
  localparam int ADDR_W    = addr_width(NUM_TAPS)
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_s_valid,
  output logic                         o_s_ready,
  input  logic signed [DATA_WIDTH-1:0] iv_s_data,
  output logic                         o_m_valid,
  input  logic                         i_m_ready,
  output logic signed [DATA_WIDTH-1:0] ov_m_data,
  input  logic                         i_coef_we,
  input  logic [ADDR_W-1:0]            iv_coef_addr,
  input  logic signed [COEF_WIDTH-1:0] iv_coef_data,
  output logic                         o_coef_ready,
  input  logic                         i_clr_flags,
  output logic                         o_sat_sticky,
  output logic                         o_busy
);

  localparam int ACC_W  = acc_width(DATA_WIDTH, COEF_WIDTH, NUM_TAPS);
  localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;
  localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(NUM_TAPS - 1);
  localparam logic [ADDR_W:0]   TAPS_EXT = (ADDR_W+1)'(NUM_TAPS);

  fir_state_e state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] tap_q, tap_d;
  logic signed [DATA_WIDTH-1:0] x_q [NUM_TAPS];
  logic signed [DATA_WIDTH-1:0] x_d [NUM_TAPS];
  logic signed [COEF_WIDTH-1:0] coef_q [NUM_TAPS];
  logic signed [COEF_WIDTH-1:0] coef_d [NUM_TAPS];
  logic signed [PROD_W-1:0] prod_q, prod_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d, acc_sum;
  logic m_valid_q, m_valid_d;
  logic signed [DATA_WIDTH-1:0] m_data_q, m_data_d, sat_data;
  logic sat_q, sat_d, sat_hit;
  logic [ADDR_W:0]   rd_full;
  logic [ADDR_W-1:0] rd_idx;
  logic coef_wr_ok;

  // Newest sample minus tap index, wrapped modulo NUM_TAPS (works for non-power-of-2 lengths).
  always_comb begin
    rd_full = {1'b0, wr_ptr_q} + TAPS_EXT - {1'b0, tap_q};
    if (rd_full >= TAPS_EXT) rd_full = rd_full - TAPS_EXT;
  end
  assign rd_idx = rd_full[ADDR_W-1:0];

  assign acc_sum    = acc_q + ACC_W'(prod_q);
  assign coef_wr_ok = (state_q == ST_IDLE) && i_coef_we && ({1'b0, iv_coef_addr} < TAPS_EXT);

  fir_mac_serial_saturate #(
    .ACC_W      (ACC_W),
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS)
  ) u_sat (
    .iv_acc  (acc_sum),
    .ov_data (sat_data),
    .o_sat   (sat_hit)
  );

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    tap_d     = tap_q;
    x_d       = x_q;
    coef_d    = coef_q;
    prod_d    = prod_q;
    acc_d     = acc_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    sat_d     = sat_q && !i_clr_flags;
    if (coef_wr_ok) coef_d[iv_coef_addr] = iv_coef_data;
    case (state_q)
      ST_IDLE: begin
        if (i_s_valid) begin
          x_d[wr_ptr_q] = iv_s_data;
          acc_d   = '0;
          prod_d  = '0;
          tap_d   = '0;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        prod_d = PROD_W'(coef_q[tap_q]) * PROD_W'(x_q[rd_idx]);
        acc_d  = acc_sum;
        if (tap_q == LAST_TAP) begin
          tap_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          tap_d = tap_q + ADDR_W'(1);
        end
      end
      ST_DRAIN: begin
        acc_d     = acc_sum;
        m_data_d  = sat_data;
        m_valid_d = 1'b1;
        sat_d     = sat_d | sat_hit;
        state_d   = ST_OUT;
      end
      ST_OUT: begin
        if (i_m_ready) begin
          m_valid_d = 1'b0;
          wr_ptr_d  = (wr_ptr_q == LAST_TAP) ? '0 : wr_ptr_q + ADDR_W'(1);
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      tap_q     <= '0;
      prod_q    <= '0;
      acc_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      sat_q     <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        x_q[i]    <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      tap_q     <= tap_d;
      prod_q    <= prod_d;
      acc_q     <= acc_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      sat_q     <= sat_d;
      x_q       <= x_d;
      coef_q    <= coef_d;
    end
  end

  assign o_s_ready    = (state_q == ST_IDLE);
  assign o_coef_ready = (state_q == ST_IDLE);
  assign o_busy       = (state_q != ST_IDLE);
  assign o_m_valid    = m_valid_q;
  assign ov_m_data    = m_data_q;
  assign o_sat_sticky = sat_q;

endmodule

// File: tb/tb_fir_mac_serial.sv
// Directed bench for fir_mac_serial: stimulus queues expected results, a monitor checks each output.
module tb_fir_mac_serial;

  localparam int DW  = 24;
  localparam int CW  = 18;
  localparam int NT  = 16;
  localparam int FB  = 17;
  localparam int AW  = 4;
  localparam int LAT = NT + 2;
  localparam int PMAX = 8388607;
  localparam int NMIN = -8388608;
  localparam int IMP  = 131072;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b1;
  logic i_s_valid = 1'b0;
  logic o_s_ready;
  logic signed [DW-1:0] iv_s_data = '0;
  logic o_m_valid;
  logic i_m_ready = 1'b1;
  logic signed [DW-1:0] ov_m_data;
  logic i_coef_we = 1'b0;
  logic [AW-1:0] iv_coef_addr = '0;
  logic signed [CW-1:0] iv_coef_data = '0;
  logic o_coef_ready;
  logic i_clr_flags = 1'b0;
  logic o_sat_sticky;
  logic o_busy;

  typedef struct {
    int data;
    bit sat;
    int acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;

  fir_mac_serial #(
    .DATA_WIDTH (DW),
    .COEF_WIDTH (CW),
    .NUM_TAPS   (NT),
    .FRAC_BITS  (FB)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_s_valid    (i_s_valid),
    .o_s_ready    (o_s_ready),
    .iv_s_data    (iv_s_data),
    .o_m_valid    (o_m_valid),
    .i_m_ready    (i_m_ready),
    .ov_m_data    (ov_m_data),
    .i_coef_we    (i_coef_we),
    .iv_coef_addr (iv_coef_addr),
    .iv_coef_data (iv_coef_data),
    .o_coef_ready (o_coef_ready),
    .i_clr_flags  (i_clr_flags),
    .o_sat_sticky (o_sat_sticky),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Called at a falling edge; the accept is the next rising edge.
  task automatic send_sample(input int d, input int e, input bit es);
    int n;
    exp_t item;
    n = 0;
    i_s_valid = 1'b1;
    iv_s_data = DW'(d);
    while (!o_s_ready && n < 400) begin
      @(negedge i_clk);
      n++;
    end
    chk("accept_wait", o_s_ready, 1);
    if (o_s_ready) begin
      item.data = e;
      item.sat = es;
      item.acc_cyc = cyc;
      exp_q.push_back(item);
    end
    @(negedge i_clk);
    i_s_valid = 1'b0;
  endtask

  task automatic write_coef(input int a, input int v);
    int n;
    n = 0;
    i_coef_we = 1'b1;
    iv_coef_addr = AW'(a);
    iv_coef_data = CW'(v);
    while (!o_coef_ready && n < 400) begin
      @(negedge i_clk);
      n++;
    end
    chk("coef_wait", o_coef_ready, 1);
    @(negedge i_clk);
    i_coef_we = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || o_busy) && n < 2000) begin
      @(negedge i_clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    #1;
    chk("rst_m_valid", o_m_valid, 0);
    chk("rst_m_data", ov_m_data, 0);
    chk("rst_sticky", o_sat_sticky, 0);
    chk("rst_busy", o_busy, 0);
    exp_q.delete();
    i_s_valid = 1'b0;
    i_coef_we = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("rst_s_ready", o_s_ready, 1);
    chk("rst_coef_ready", o_coef_ready, 1);
  endtask

  initial begin : monitor
    logic prev_valid;
    logic signed [DW-1:0] held;
    exp_t e;
    prev_valid = 1'b0;
    held = '0;
    forever begin
      @(negedge i_clk);
      #2;
      if (!i_rst_n) begin
        prev_valid = 1'b0;
      end else begin
        if (o_m_valid) begin
          chk("s_ready_while_out", o_s_ready, 0);
          if (!prev_valid) begin
            if (exp_q.size() == 0) chk("unexpected_output", exp_q.size(), 1);
            else begin
              chk("latency", cyc - exp_q[0].acc_cyc, LAT);
              chk("sticky", o_sat_sticky, exp_q[0].sat);
            end
            held = ov_m_data;
          end else begin
            chk("hold_data", ov_m_data, held);
          end
          if (i_m_ready && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("data", ov_m_data, e.data);
          end
        end
        prev_valid = o_m_valid;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge i_clk);
    do_reset();

    // Impulse: h[k]=k+1, input 2^17 so the Q17 result equals h[k].
    for (int k = 0; k < NT; k++) write_coef(k, k + 1);
    for (int n = 0; n <= NT; n++) send_sample((n == 0) ? IMP : 0, (n < NT) ? n + 1 : 0, 1'b0);
    wait_idle();

    // Backpressure: result held 20 cycles, second sample waits and is not lost.
    i_m_ready = 1'b0;
    send_sample(3 * IMP, 3, 1'b0);
    fork
      send_sample(0, 6, 1'b0);
      begin
        repeat (NT + 1 + 20) @(negedge i_clk);
        i_m_ready = 1'b1;
      end
    join
    wait_idle();

    // Unity DC gain with truncation: floor(n*1000/16).
    do_reset();
    for (int k = 0; k < NT; k++) write_coef(k, 8192);
    for (int n = 1; n <= NT + 1; n++) send_sample(1000, (((n > NT) ? NT : n) * 1000) / 16, 1'b0);
    wait_idle();

    // Saturation with all taps at 2^17-1.
    do_reset();
    for (int k = 0; k < NT; k++) write_coef(k, 131071);
    send_sample(PMAX, 8388543, 1'b0);
    send_sample(PMAX, PMAX, 1'b1);
    wait_idle();
    i_clr_flags = 1'b1;
    @(negedge i_clk);
    i_clr_flags = 1'b0;
    chk("clr_sticky", o_sat_sticky, 0);
    send_sample(NMIN, 8388542, 1'b0);
    send_sample(NMIN, -2, 1'b0);
    send_sample(NMIN, -8388546, 1'b0);
    i_clr_flags = 1'b1;
    send_sample(NMIN, NMIN, 1'b1);
    wait_idle();
    chk("clr_after_set", o_sat_sticky, 0);
    i_clr_flags = 1'b0;
    send_sample(NMIN, NMIN, 1'b1);
    wait_idle();

    // Reset during MAC tap 4, then an impulse through zeroed coefficients.
    send_sample(0, 0, 1'b0);
    repeat (4) @(negedge i_clk);
    chk("busy_before_rst", o_busy, 1);
    do_reset();
    send_sample(IMP, 0, 1'b0);
    wait_idle();

    // Same-edge write+accept uses the new h[0]; a write while busy is dropped.
    i_coef_we = 1'b1;
    iv_coef_addr = '0;
    iv_coef_data = 18'sd5;
    send_sample(IMP, 5, 1'b0);
    i_coef_we = 1'b0;
    repeat (3) @(negedge i_clk);
    i_coef_we = 1'b1;
    iv_coef_data = 18'sd100;
    chk("coef_ready_busy", o_coef_ready, 0);
    @(negedge i_clk);
    i_coef_we = 1'b0;
    send_sample(IMP, 5, 1'b0);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
